jam_gen: RTL and testbench

JAM_GEN -- requirements
Module: jam_gen

---
 rtl/jam_gen_pkg.sv | 34 +++
 rtl/jam_next_perm.sv | 85 ++++++++
 rtl/jam_gen.sv | 184 ++++++++++++++++++
 tb/tb_jam_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_gen_pkg.sv
// ---------------------------------------------------------------------------
// jam_gen_pkg
//
// Shared declarations for the exhaustive assignment-problem solver:
//   - state_t      : controller states (IDLE, EVAL, UPD, DONE)
//   - DEFAULT_*    : default worker count, cost width and match-count width
//   - index_width  : width of a worker/job index for N workers
//   - sum_width    : width of a total-cost accumulator that can never overflow
// ---------------------------------------------------------------------------
package jam_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      UPD  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEFAULT_N   = 8;
   localparam int DEFAULT_CW  = 7;
   localparam int DEFAULT_MCW = 4;

   // Index width is clog2(N), but never narrower than one bit.
   function automatic int index_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // N costs of CW bits each sum to less than N * 2^CW, so CW + clog2(N)
   // bits already suffice; the extra bit keeps a comfortable margin.
   function automatic int sum_width(input int cw, input int n);
      return cw + $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/jam_next_perm.sv
// ---------------------------------------------------------------------------
// jam_next_perm
//
// Purely combinational lexicographic successor of a permutation of 0..N-1.
//
// Ports:
//   perm       in  N*IW : current permutation, entry i in bits [i*IW +: IW]
//   next_perm  out N*IW : lexicographic successor (don't-care when last = 1)
//   last       out 1    : perm is strictly descending, no successor exists
//
// Classic algorithm, all in one cycle:
//   1. pivot = largest i with perm[i] < perm[i+1]
//   2. succ  = largest j > pivot with perm[j] > perm[pivot]
//   3. swap perm[pivot] and perm[succ]
//   4. reverse the suffix after pivot
// ---------------------------------------------------------------------------
module jam_next_perm
   import jam_gen_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int IW = index_width(N)
) (
   input  logic [N*IW-1:0] perm,
   output logic [N*IW-1:0] next_perm,
   output logic            last
);

   logic [IW-1:0] cur     [N];
   logic [IW-1:0] swapped [N];
   logic [IW-1:0] pivot_idx;
   logic [IW-1:0] succ_idx;
   logic [IW-1:0] src_idx;
   logic          found;

   // Unpack the flat permutation vector into an indexable array.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         cur[i] = perm[i*IW +: IW];
      end
   end

   // Pivot search, swap and suffix reversal. Later loop iterations overwrite
   // earlier ones, so each search naturally keeps the largest qualifying index.
   always_comb begin
      found     = 1'b0;
      pivot_idx = '0;
      succ_idx  = '0;
      src_idx   = '0;
      next_perm = '0;
      for (int i = 0; i < N; i++) begin
         swapped[i] = cur[i];
      end

      for (int i = 0; i < N - 1; i++) begin
         if (cur[i] < cur[i+1]) begin
            found     = 1'b1;
            pivot_idx = IW'(i);
         end
      end

      for (int j = 0; j < N; j++) begin
         if ((IW'(j) > pivot_idx) && (cur[j] > cur[pivot_idx])) begin
            succ_idx = IW'(j);
         end
      end

      swapped[pivot_idx] = cur[succ_idx];
      swapped[succ_idx]  = cur[pivot_idx];

      // Position m after the pivot takes the mirrored element N+pivot-m.
      // The modulo-2^IW arithmetic is exact because the result lies in
      // pivot+1..N-1.
      for (int m = 0; m < N; m++) begin
         if (IW'(m) > pivot_idx) begin
            src_idx                = pivot_idx + IW'(N) - IW'(m);
            next_perm[m*IW +: IW]  = swapped[src_idx];
         end else begin
            next_perm[m*IW +: IW]  = swapped[m];
         end
      end

      last = ~found;
   end

endmodule

// File: rtl/jam_gen.sv
// ---------------------------------------------------------------------------
// jam_gen
//
// Exhaustive solver for the N x N assignment problem. Walks every
// permutation in lexicographic order, sums cost[i][perm[i]] by querying an
// external combinational cost table one entry per cycle, and tracks the
// minimum total, how many permutations reach it (saturating) and the first
// permutation that reached it.
//
// Ports:
//   CLK         in  1     : clock, rising edge
//   RST         in  1     : synchronous active-high reset
//   Start       in  1     : run request, honoured only in IDLE or DONE
//   Busy        out 1     : high while evaluating/updating
//   W           out IW    : worker index of the current cost lookup
//   J           out IW    : job index of the current cost lookup
//   Cost        in  CW    : cost[W][J], returned in the same cycle
//   MinCost     out SW    : minimum total assignment cost
//   MatchCount  out MCW   : permutations achieving MinCost, saturating
//   BestPerm    out N*IW  : job of worker i in bits [i*IW +: IW]
//   Valid       out 1     : results final
//
// Each permutation costs N EVAL cycles plus one UPD cycle.
// ---------------------------------------------------------------------------
module jam_gen
   import jam_gen_pkg::*;
#(
   parameter  int N   = DEFAULT_N,
   parameter  int CW  = DEFAULT_CW,
   parameter  int MCW = DEFAULT_MCW,
   localparam int IW  = index_width(N),
   localparam int SW  = sum_width(CW, N)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            Start,
   output logic            Busy,
   output logic [IW-1:0]   W,
   output logic [IW-1:0]   J,
   input  logic [CW-1:0]   Cost,
   output logic [SW-1:0]   MinCost,
   output logic [MCW-1:0]  MatchCount,
   output logic [N*IW-1:0] BestPerm,
   output logic            Valid
);

   // Identity permutation: worker i assigned job i.
   function automatic logic [N*IW-1:0] identity_perm();
      logic [N*IW-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) begin
         p[i*IW +: IW] = IW'(i);
      end
      return p;
   endfunction

   localparam logic [N*IW-1:0] IDENTITY  = identity_perm();
   localparam logic [IW-1:0]   K_LAST    = IW'(N - 1);
   localparam logic [MCW-1:0]  COUNT_MAX = {MCW{1'b1}};

   state_t          state_q;
   state_t          state_d;
   logic [IW-1:0]   k_q;
   logic [SW-1:0]   acc_q;
   logic [N*IW-1:0] perm_q;
   logic            first_q;
   logic [IW-1:0]   perm_arr [N];
   logic [N*IW-1:0] next_perm;
   logic            last_perm;

   jam_next_perm #(
      .N  (N),
      .IW (IW)
   ) u_next_perm (
      .perm      (perm_q),
      .next_perm (next_perm),
      .last      (last_perm)
   );

   // Indexable view of the current permutation for the J lookup.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         perm_arr[i] = perm_q[i*IW +: IW];
      end
   end

   // State register; reset wins over everything and aborts any run.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic plus the cost-lookup address. W/J are parked at zero
   // outside EVAL so the cost table sees a stable address when idle.
   always_comb begin
      state_d = state_q;
      Busy    = 1'b0;
      W       = '0;
      J       = '0;
      case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               state_d = EVAL;
            end
         end
         EVAL: begin
            Busy = 1'b1;
            W    = k_q;
            J    = perm_arr[k_q];
            if (k_q == K_LAST) begin
               state_d = UPD;
            end
         end
         UPD: begin
            Busy    = 1'b1;
            state_d = last_perm ? DONE : EVAL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: accumulate costs during EVAL, fold the finished total into
   // the running best in UPD, then either step to the successor or finish.
   // Starting a run clears old results so nothing stale survives into it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         k_q        <= '0;
         acc_q      <= '0;
         perm_q     <= '0;
         first_q    <= 1'b0;
         MinCost    <= '0;
         MatchCount <= '0;
         BestPerm   <= '0;
         Valid      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (Start) begin
                  k_q        <= '0;
                  acc_q      <= '0;
                  perm_q     <= IDENTITY;
                  first_q    <= 1'b1;
                  MinCost    <= '0;
                  MatchCount <= '0;
                  BestPerm   <= '0;
                  Valid      <= 1'b0;
               end
            end
            EVAL: begin
               acc_q <= acc_q + SW'(Cost);
               if (k_q != K_LAST) begin
                  k_q <= k_q + IW'(1);
               end
            end
            UPD: begin
               if (first_q || (acc_q < MinCost)) begin
                  MinCost    <= acc_q;
                  MatchCount <= MCW'(1);
                  BestPerm   <= perm_q;
               end else if ((acc_q == MinCost) && (MatchCount != COUNT_MAX)) begin
                  MatchCount <= MatchCount + MCW'(1);
               end
               first_q <= 1'b0;
               if (last_perm) begin
                  Valid <= 1'b1;
               end else begin
                  perm_q <= next_perm;
                  k_q    <= '0;
                  acc_q  <= '0;
               end
            end
            default: begin
               k_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jam_gen.sv
// ---------------------------------------------------------------------------
// tb_jam_gen
//
// Drives two jam_gen instances (N=3 and N=4) sharing one clock and reset.
// Expected results come from a brute-force model that enumerates every
// N-digit base-N tuple in increasing order (worker 0 most significant),
// discards tuples with repeated jobs and keeps the first strict minimum.
// ---------------------------------------------------------------------------
module tb_jam_gen;

   localparam int CW  = 7;
   localparam int MCW = 4;
   localparam int N3  = 3;
   localparam int IW3 = 2;
   localparam int SW3 = 10;
   localparam int N4  = 4;
   localparam int IW4 = 2;
   localparam int SW4 = 10;

   logic CLK = 1'b0;
   logic RST;

   logic                 Start3, Busy3, Valid3;
   logic [IW3-1:0]       W3, J3;
   logic [CW-1:0]        Cost3;
   logic [SW3-1:0]       MinCost3;
   logic [MCW-1:0]       MatchCount3;
   logic [N3*IW3-1:0]    BestPerm3;

   logic                 Start4, Busy4, Valid4;
   logic [IW4-1:0]       W4, J4;
   logic [CW-1:0]        Cost4;
   logic [SW4-1:0]       MinCost4;
   logic [MCW-1:0]       MatchCount4;
   logic [N4*IW4-1:0]    BestPerm4;

   logic [CW-1:0] costTab3 [N3][N3];
   logic [CW-1:0] costTab4 [N4][N4];

   int testsRun    = 0;
   int testsFailed = 0;

   int modelCost [8][8];
   int refMin;
   int refCount;
   int refPerm [8];

   always #5 CLK = ~CLK;

   assign Cost3 = costTab3[W3][J3];
   assign Cost4 = costTab4[W4][J4];

   jam_gen #(.N(N3), .CW(CW), .MCW(MCW)) dut3 (
      .CLK        (CLK),
      .RST        (RST),
      .Start      (Start3),
      .Busy       (Busy3),
      .W          (W3),
      .J          (J3),
      .Cost       (Cost3),
      .MinCost    (MinCost3),
      .MatchCount (MatchCount3),
      .BestPerm   (BestPerm3),
      .Valid      (Valid3)
   );

   jam_gen #(.N(N4), .CW(CW), .MCW(MCW)) dut4 (
      .CLK        (CLK),
      .RST        (RST),
      .Start      (Start4),
      .Busy       (Busy4),
      .W          (W4),
      .J          (J4),
      .Cost       (Cost4),
      .MinCost    (MinCost4),
      .MatchCount (MatchCount4),
      .BestPerm   (BestPerm4),
      .Valid      (Valid4)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int fact(input int n);
      int f;
      f = 1;
      for (int i = 2; i <= n; i++) f = f * i;
      return f;
   endfunction

   // Brute force over all n^n tuples; increasing tuple value is
   // lexicographic order, so only a strictly smaller sum replaces the best.
   task automatic referenceModel(input int n);
      int total, rem, used, sum;
      bit ok;
      int tuple [8];
      total = 1;
      for (int i = 0; i < n; i++) total = total * n;
      refMin   = 0;
      refCount = 0;
      for (int i = 0; i < 8; i++) begin
         refPerm[i] = 0;
         tuple[i]   = 0;
      end
      for (int t = 0; t < total; t++) begin
         rem = t;
         for (int i = n - 1; i >= 0; i--) begin
            tuple[i] = rem % n;
            rem      = rem / n;
         end
         used = 0;
         ok   = 1'b1;
         for (int i = 0; i < n; i++) begin
            if ((used & (1 << tuple[i])) != 0) ok = 1'b0;
            used = used | (1 << tuple[i]);
         end
         if (ok) begin
            sum = 0;
            for (int i = 0; i < n; i++) sum = sum + modelCost[i][tuple[i]];
            if (refCount == 0 || sum < refMin) begin
               refMin   = sum;
               refCount = 1;
               refPerm  = tuple;
            end else if (sum == refMin) begin
               refCount++;
            end
         end
      end
      if (refCount > (1 << MCW) - 1) refCount = (1 << MCW) - 1;
   endtask

   function automatic logic [63:0] packPerm(input int n, input int iw);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (64'(refPerm[i]) << (i * iw));
      return v;
   endfunction

   task automatic setStart(input int n, input logic v);
      if (n == N3) Start3 = v;
      else         Start4 = v;
   endtask

   function automatic logic getValid(input int n);
      return (n == N3) ? Valid3 : Valid4;
   endfunction

   function automatic logic getBusy(input int n);
      return (n == N3) ? Busy3 : Busy4;
   endfunction

   task automatic loadModel(input int n);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++)
            modelCost[i][j] = (n == N3) ? int'(costTab3[i][j]) : int'(costTab4[i][j]);
   endtask

   task automatic randomCosts(input int n, input int maxCost);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n; j++) begin
            if (n == N3) costTab3[i][j] = CW'($urandom_range(0, maxCost));
            else         costTab4[i][j] = CW'($urandom_range(0, maxCost));
         end
   endtask

   // Pulse Start, then count edges until Valid (bounded). pulseAt > 0
   // re-asserts Start mid-run, which the design must ignore.
   task automatic applyStimulus(input int n, input int pulseAt, output int validEdge);
      int budget;
      budget    = fact(n) * (n + 1) + 40;
      validEdge = -1;
      @(negedge CLK);
      setStart(n, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      setStart(n, 1'b0);
      checkOutput("startValidLow", 64'(getValid(n)), 64'd0);
      checkOutput("startBusy", 64'(getBusy(n)), 64'd1);
      for (int e = 1; e <= budget; e++) begin
         @(posedge CLK);
         @(negedge CLK);
         setStart(n, (e == pulseAt) ? 1'b1 : 1'b0);
         if (getValid(n)) begin
            validEdge = e;
            break;
         end
      end
      setStart(n, 1'b0);
   endtask

   task automatic checkResults(input int n, input string tag, input int validEdge);
      checkOutput({tag, ".edge"}, 64'(validEdge), 64'(fact(n) * (n + 1)));
      if (n == N3) begin
         checkOutput({tag, ".min"},   64'(MinCost3),    64'(refMin));
         checkOutput({tag, ".count"}, 64'(MatchCount3), 64'(refCount));
         checkOutput({tag, ".perm"},  64'(BestPerm3),   packPerm(n, IW3));
         checkOutput({tag, ".idle"},  64'({Busy3, W3, J3}), 64'd0);
      end else begin
         checkOutput({tag, ".min"},   64'(MinCost4),    64'(refMin));
         checkOutput({tag, ".count"}, 64'(MatchCount4), 64'(refCount));
         checkOutput({tag, ".perm"},  64'(BestPerm4),   packPerm(n, IW4));
         checkOutput({tag, ".idle"},  64'({Busy4, W4, J4}), 64'd0);
      end
   endtask

   task automatic checkZero4(input string tag);
      checkOutput({tag, ".valid"}, 64'(Valid4),      64'd0);
      checkOutput({tag, ".busy"},  64'(Busy4),       64'd0);
      checkOutput({tag, ".wj"},    64'({W4, J4}),    64'd0);
      checkOutput({tag, ".min"},   64'(MinCost4),    64'd0);
      checkOutput({tag, ".count"}, 64'(MatchCount4), 64'd0);
      checkOutput({tag, ".perm"},  64'(BestPerm4),   64'd0);
   endtask

   task automatic runAndCheck(input int n, input string tag);
      int ve;
      loadModel(n);
      referenceModel(n);
      applyStimulus(n, 0, ve);
      checkResults(n, tag, ve);
   endtask

   initial begin
      int ve;
      RST    = 1'b1;
      Start3 = 1'b0;
      Start4 = 1'b0;
      for (int i = 0; i < N3; i++) for (int j = 0; j < N3; j++) costTab3[i][j] = '0;
      for (int i = 0; i < N4; i++) for (int j = 0; j < N4; j++) costTab4[i][j] = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkZero4("reset");
      checkOutput("reset3", 64'({Valid3, Busy3, MinCost3, MatchCount3, BestPerm3}), 64'd0);
      RST = 1'b0;

      // Directed 3x3: unique optimum 1+2+6 = 9 with worker0->job1,
      // worker1->job0, worker2->job2.
      costTab3[0][0] = 7'd5; costTab3[0][1] = 7'd1; costTab3[0][2] = 7'd9;
      costTab3[1][0] = 7'd2; costTab3[1][1] = 7'd8; costTab3[1][2] = 7'd3;
      costTab3[2][0] = 7'd7; costTab3[2][1] = 7'd4; costTab3[2][2] = 7'd6;
      runAndCheck(N3, "dir3");
      checkOutput("dir3.minConst",   64'(MinCost3),    64'd9);
      checkOutput("dir3.countConst", 64'(MatchCount3), 64'd1);
      checkOutput("dir3.permConst",  64'(BestPerm3),   64'b10_00_01);

      // Random 3x3: small cost range forces ties, full range exercises sums.
      for (int r = 0; r < 4; r++) begin
         randomCosts(N3, (r % 2 == 0) ? 3 : 127);
         runAndCheck(N3, "rnd3");
      end

      // All-zero 4x4: all 24 permutations tie, count saturates at 15.
      for (int i = 0; i < N4; i++) for (int j = 0; j < N4; j++) costTab4[i][j] = '0;
      runAndCheck(N4, "zero4");
      checkOutput("zero4.satConst", 64'(MatchCount4), 64'd15);
      checkOutput("zero4.idConst",  64'(BestPerm4),   64'b11_10_01_00);

      // Mid-run Start is ignored; a second Start in DONE repeats the result.
      randomCosts(N4, 15);
      loadModel(N4);
      referenceModel(N4);
      applyStimulus(N4, 30, ve);
      checkResults(N4, "midStart4", ve);
      applyStimulus(N4, 0, ve);
      checkResults(N4, "restart4", ve);

      // Reset 50 cycles into a run aborts it and clears every output.
      randomCosts(N4, 127);
      @(negedge CLK);
      Start4 = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Start4 = 1'b0;
      repeat (49) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      checkZero4("abort4");
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checkOutput("abort4.stayIdle", 64'({Valid4, Busy4}), 64'd0);
      runAndCheck(N4, "afterAbort4");

      // Random 4x4 sweep.
      for (int r = 0; r < 4; r++) begin
         randomCosts(N4, (r % 2 == 0) ? 2 : 127);
         runAndCheck(N4, "rnd4");
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
